// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ bursting producers.
// A grant is held for up to BURST_L words, is revoked after IDLE_TO idle cycles, and never writes into a full FIFO.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned BURST_L = 4,
    parameter int unsigned IDLE_TO = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    input  logic                      fifo_almst_full,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      to_err
);

    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BW = $clog2(BURST_L) + 1;
    localparam int unsigned TW = 8;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_XFER = 1'b1;

    logic              state, state_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [GW-1:0]     last_gnt, last_gnt_nxt;
    logic [BW-1:0]     beat_cnt, beat_cnt_nxt;
    logic [TW-1:0]     to_cnt, to_cnt_nxt;
    logic              to_err_nxt;

    logic              valid_g;
    logic              last_g;
    logic              wr_beat;
    logic [GW-1:0]     rr_idx;
    logic [GW-1:0]     rr_win;
    logic              rr_found;

    // Granted requester's handshake signals, selected by the one-hot grant
    always_comb begin
        valid_g = |(req_valid & grant);
        last_g  = |(req_last & grant);
        wr_beat = (state == S_XFER) && valid_g && !fifo_full;
    end

    // Round-robin search starting just above the previous winner
    always_comb begin
        rr_idx   = last_gnt;
        rr_win   = last_gnt;
        rr_found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rr_idx = (rr_idx == GW'(N_REQ - 1)) ? '0 : rr_idx + GW'(1);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_gnt_nxt = last_gnt;
        beat_cnt_nxt = beat_cnt;
        to_cnt_nxt   = to_cnt;
        to_err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rr_found && !fifo_almst_full) begin
                    state_nxt    = S_XFER;
                    last_gnt_nxt = rr_win;
                    beat_cnt_nxt = '0;
                    to_cnt_nxt   = '0;
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        grant_nxt[i] = (GW'(i) == rr_win);
                    end
                end
            end
            S_XFER: begin
                if (wr_beat) begin
                    beat_cnt_nxt = beat_cnt + BW'(1);
                    to_cnt_nxt   = '0;
                    if (last_g || (beat_cnt == BW'(BURST_L - 1))) begin
                        state_nxt = S_IDLE;
                        grant_nxt = '0;
                    end
                end else if (!valid_g) begin
                    // Backpressure with valid high holds the counter; only an absent producer times out
                    if (to_cnt >= TW'(IDLE_TO - 1)) begin
                        state_nxt  = S_IDLE;
                        grant_nxt  = '0;
                        to_err_nxt = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            grant    <= '0;
            last_gnt <= GW'(N_REQ - 1);
            beat_cnt <= '0;
            to_cnt   <= '0;
            to_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_gnt <= last_gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
            to_err   <= to_err_nxt;
        end
    end

    // FIFO-side and handshake outputs, all forced low outside XFER
    always_comb begin
        busy       = (state == S_XFER);
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        if (state == S_XFER) begin
            req_ready  = grant & {N_REQ{~fifo_full}};
            fifo_wr_en = valid_g & ~fifo_full;
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (grant[i]) begin
                    fifo_data = fifo_data | req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bench-side producers with hand-derived cycle expectations.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int DW = 24;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_data;
    logic            fifo_wr_en;
    logic            fifo_full;
    logic            fifo_almst_full;
    logic [N-1:0]    grant;
    logic            busy;
    logic            to_err;

    int vec_cnt;
    int miscmp;

    // Producer model: words sent, word limit (-1 = endless), burst length for req_last (0 = never)
    logic [N-1:0] en;
    int sent  [N];
    int limit [N];
    int blen  [N];

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(24), .BURST_L(4), .IDLE_TO(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_data       (fifo_data),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_full       (fifo_full),
        .fifo_almst_full (fifo_almst_full),
        .grant           (grant),
        .busy            (busy),
        .to_err          (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input int i, input int k);
        return DW'(32'hA00000 + (i << 16) + k);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (limit[i] < 0 || sent[i] < limit[i]);
            req_last[i]  = req_valid[i] && blen[i] > 0 && ((sent[i] % blen[i]) == blen[i] - 1);
            req_data[i*DW +: DW] = data_of(i, sent[i]);
        end
    endtask

    // Called at the sampling point; completes the edge and refreshes producer inputs
    task automatic adv();
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_full = 1'b0;
        fifo_almst_full = 1'b0;
        en = '0;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            limit[i] = -1;
            blen[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fifo_full = 1'b0;
        fifo_almst_full = 1'b0;
        en = 4'b1111;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            limit[i] = -1;
            blen[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0000) begin miscmp++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        vec_cnt++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vec_cnt++; if (req_ready !== 4'b0000) begin miscmp++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        vec_cnt++; if (fifo_wr_en !== 1'b0) begin miscmp++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
        vec_cnt++; if (fifo_data !== 24'h0) begin miscmp++; $display("FAIL reset_data got=%h exp=000000", fifo_data); end
        vec_cnt++; if (to_err !== 1'b0) begin miscmp++; $display("FAIL reset_to_err got=%b exp=0", to_err); end
        en = '0;
        drive();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        en[0] = 1'b1; limit[0] = 3; blen[0] = 3;
        drive();
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0000 || req_ready !== 4'b0000) begin
            miscmp++; $display("FAIL single_latency grant=%b ready=%b exp 0000/0000", grant, req_ready); end
        adv();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++; if (grant !== 4'b0001 || busy !== 1'b1) begin
                miscmp++; $display("FAIL single_grant beat=%0d grant=%b busy=%b exp 0001/1", k, grant, busy); end
            vec_cnt++; if (fifo_wr_en !== 1'b1 || fifo_data !== data_of(0, k)) begin
                miscmp++; $display("FAIL single_write beat=%0d wr_en=%b data=%h exp 1/%h", k, fifo_wr_en, fifo_data, data_of(0, k)); end
            adv();
        end
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0 || grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
            miscmp++; $display("FAIL single_end busy=%b grant=%b wr_en=%b exp 0/0000/0", busy, grant, fifo_wr_en); end
    endtask

    task automatic test_all_requesting();
        int writes;
        logic [N-1:0]  eg;
        logic          ew;
        logic [DW-1:0] ed;
        do_reset();
        en = 4'b1111;
        drive();
        @(negedge clk);
        adv();
        writes = 0;
        for (int c = 0; c < 24; c++) begin
            int b, p, r;
            b = c / 5; p = c % 5; r = b % 4;
            if (p < 4) begin
                eg = 4'(1 << r); ew = 1'b1; ed = data_of(r, (b / 4) * 4 + p);
            end else begin
                eg = 4'b0000; ew = 1'b0; ed = '0;
            end
            @(negedge clk);
            if (fifo_wr_en === 1'b1) writes++;
            vec_cnt++; if (grant !== eg) begin
                miscmp++; $display("FAIL all_grant cyc=%0d got=%b exp=%b", c, grant, eg); end
            vec_cnt++; if (fifo_wr_en !== ew || fifo_data !== ed) begin
                miscmp++; $display("FAIL all_write cyc=%0d wr_en=%b data=%h exp %b/%h", c, fifo_wr_en, fifo_data, ew, ed); end
            adv();
        end
        vec_cnt++; if (writes !== 20) begin miscmp++; $display("FAIL all_count got=%0d exp=20", writes); end
    endtask

    task automatic test_backpressure();
        do_reset();
        en[2] = 1'b1; limit[2] = 4;
        drive();
        @(negedge clk);
        adv();
        for (int n = 1; n <= 8; n++) begin
            fifo_full = (n >= 2 && n <= 4);
            @(negedge clk);
            vec_cnt++; if (to_err !== 1'b0) begin miscmp++; $display("FAIL bp_to_err cyc=%0d got=%b exp=0", n, to_err); end
            if (n >= 2 && n <= 4) begin
                vec_cnt++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0100) begin
                    miscmp++; $display("FAIL bp_stall cyc=%0d wr_en=%b ready=%b grant=%b exp 0/0000/0100", n, fifo_wr_en, req_ready, grant); end
            end else if (n == 8) begin
                vec_cnt++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
                    miscmp++; $display("FAIL bp_end busy=%b wr_en=%b exp 0/0", busy, fifo_wr_en); end
            end else begin
                int k;
                k = (n == 1) ? 0 : n - 4;
                vec_cnt++; if (fifo_wr_en !== 1'b1 || fifo_data !== data_of(2, k) || req_ready !== 4'b0100) begin
                    miscmp++; $display("FAIL bp_write cyc=%0d wr_en=%b data=%h ready=%b exp 1/%h/0100", n, fifo_wr_en, fifo_data, req_ready, data_of(2, k)); end
            end
            adv();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_almst_full();
        do_reset();
        fifo_almst_full = 1'b1;
        en[2] = 1'b1; limit[2] = 1; blen[2] = 1;
        drive();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vec_cnt++; if (grant !== 4'b0000) begin miscmp++; $display("FAIL af_hold cyc=%0d grant=%b exp=0000", n, grant); end
            adv();
        end
        fifo_almst_full = 1'b0;
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0000) begin miscmp++; $display("FAIL af_fall grant=%b exp=0000", grant); end
        adv();
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1) begin
            miscmp++; $display("FAIL af_grant grant=%b wr_en=%b exp 0100/1", grant, fifo_wr_en); end
        adv();
    endtask

    task automatic test_timeout();
        do_reset();
        en[1] = 1'b1; limit[1] = 1;
        en[2] = 1'b1;
        drive();
        @(negedge clk);
        adv();
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0010 || fifo_data !== data_of(1, 0)) begin
            miscmp++; $display("FAIL to_first grant=%b data=%h exp 0010/%h", grant, fifo_data, data_of(1, 0)); end
        adv();
        for (int n = 2; n <= 9; n++) begin
            @(negedge clk);
            vec_cnt++; if (grant !== 4'b0010 || to_err !== 1'b0) begin
                miscmp++; $display("FAIL to_wait cyc=%0d grant=%b to_err=%b exp 0010/0", n, grant, to_err); end
            adv();
        end
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0000 || to_err !== 1'b1 || busy !== 1'b0) begin
            miscmp++; $display("FAIL to_revoke grant=%b to_err=%b busy=%b exp 0000/1/0", grant, to_err, busy); end
        adv();
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0100 || to_err !== 1'b0) begin
            miscmp++; $display("FAIL to_next grant=%b to_err=%b exp 0100/0", grant, to_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en[0] = 1'b1; blen[0] = 4; limit[0] = 8;
        drive();
        @(negedge clk);
        adv();
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 5 || n == 10) begin
                vec_cnt++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
                    miscmp++; $display("FAIL b2b_bubble cyc=%0d busy=%b wr_en=%b exp 0/0", n, busy, fifo_wr_en); end
            end else begin
                int k;
                k = (n < 5) ? n - 1 : n - 2;
                vec_cnt++; if (grant !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_data !== data_of(0, k)) begin
                    miscmp++; $display("FAIL b2b_write cyc=%0d grant=%b wr_en=%b data=%h exp 0001/1/%h", n, grant, fifo_wr_en, fifo_data, data_of(0, k)); end
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en[3] = 1'b1;
        drive();
        @(negedge clk);
        adv();
        @(negedge clk);
        adv();
        #1;
        vec_cnt++; if (fifo_wr_en !== 1'b1 || grant !== 4'b1000) begin
            miscmp++; $display("FAIL rm_before wr_en=%b grant=%b exp 1/1000", fifo_wr_en, grant); end
        reset = 1'b1;
        #1;
        vec_cnt++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0000 || req_ready !== 4'b0000) begin
            miscmp++; $display("FAIL rm_async wr_en=%b grant=%b ready=%b exp 0/0000/0000", fifo_wr_en, grant, req_ready); end
        en = 4'b1111;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0000) begin miscmp++; $display("FAIL rm_idle grant=%b exp=0000", grant); end
        adv();
        @(negedge clk);
        vec_cnt++; if (grant !== 4'b0001) begin miscmp++; $display("FAIL rm_first grant=%b exp=0001", grant); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_cnt = 0;
        miscmp = 0;
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_almst_full();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port among N_REQ producers. Each producer pushes bursts over a valid/ready handshake. The arbiter grants one producer at a time, locks the grant for a burst of up to BURST_L words, and gates writes against the FIFO full and almost-full flags so the FIFO never sees a write while full. It sits directly in front of the FIFO's data_in/wr_en inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 24, data width; must match the FIFO DATA_W
- BURST_L, 4, maximum words per grant (1..16)
- IDLE_TO, 8, consecutive cycles with valid low while granted before the grant is revoked (1..255)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester word valid
- req_last  in  N_REQ  per-requester end-of-burst marker, qualified by valid
- req_data  in  N_REQ*DATA_W  flat data bus; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  per-requester accept; a word transfers when valid and ready are both high
- fifo_data  out  DATA_W  to the FIFO data_in
- fifo_wr_en  out  1  to the FIFO wr_en
- fifo_full  in  1  FIFO full flag
- fifo_almst_full  in  1  FIFO almost-full flag
- grant  out  N_REQ  one-hot registered grant; all zero when idle
- busy  out  1  high in XFER
- to_err  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- States: IDLE and XFER. All state is in flops; everything else is combinational from state and inputs.
- **IDLE:**
  - If any req_valid is high and fifo_almst_full=0, pick a winner by round robin.
  - Search starts at index last_gnt+1 mod N_REQ and proceeds upward with wrap.
  - Load grant with the winner (one-hot), set last_gnt to the winner, clear beat_cnt and to_cnt, and go to XFER.
  - Otherwise stay in IDLE.
- **XFER, granted index g:**
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_data = req_data slice g (mux by grant; driven even when wr_en=0).
- **On a write beat:**
  - beat_cnt increments and to_cnt clears.
  - If req_last[g]=1 or beat_cnt=BURST_L-1, clear grant and return to IDLE.
- **Stall handling:**
  - req_valid[g]=0 increments to_cnt.
  - If to_cnt reaches IDLE_TO-1 while valid is still low, clear grant, go to IDLE, and pulse to_err for one cycle.
  - fifo_full=1 with valid high does not advance to_cnt; backpressure is not a timeout.
- Outside XFER, req_ready=0, fifo_wr_en=0 and fifo_data=0.
- Widths:
  - beat_cnt is clog2(BURST_L)+1 bits.
  - to_cnt is 8 bits.
  - last_gnt is clog2(N_REQ) bits; its wrap uses explicit compare to N_REQ-1, not natural overflow.
- almst_full is checked only at grant time. A granted burst continues into the almost-full region and stalls only on fifo_full.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_gnt=N_REQ-1 (requester 0 wins first), beat_cnt=0, to_cnt=0, to_err=0.
  - busy=0, req_ready=0, fifo_wr_en=0, fifo_data=0.
- reset asserted mid-burst clears state asynchronously; fifo_wr_en and req_ready drop in the same cycle with no clock edge. The word in flight is not written.
- Arbitration latency:
  - req_valid seen in IDLE at edge T gives grant and busy high after T.
  - The first write can occur in cycle T+1.
- Throughput: one word per cycle while granted and not full. Exactly one IDLE bubble cycle between consecutive bursts, including same-requester bursts.
- req_last on the BURST_L-th beat is a single termination, not two.
- A req_last beat blocked by fifo_full is held until accepted; termination happens on the accepting edge.
- to_err is registered and asserts in the cycle after the revoking edge.

## Test plan
- **Single requester:** after reset, req_valid[0]=1 with 3 words, req_last on the 3rd.
  - grant=0001 one cycle after valid.
  - fifo_wr_en high for 3 consecutive cycles with data D0,D1,D2.
  - Then IDLE; busy=0 on the 4th cycle after grant.
- **All requesting:** all 4 requesters valid continuously, no req_last, BURST_L=4.
  - Grant order 0,1,2,3,0.
  - Each grant gives exactly 4 writes, separated by 1 idle cycle.
  - 20 writes in 24 cycles after the first grant.
- **Backpressure:** fifo_full=1 for cycles 2-4 of a burst by requester 2.
  - fifo_wr_en=0 and req_ready[2]=0 during those cycles.
  - No to_err.
  - The burst completes with 4 words, in order, after full drops.
- **Almost full:** fifo_almst_full=1 in IDLE with req_valid=0100.
  - No grant while the flag is high.
  - Grant=0100 one cycle after the flag falls.
- **Timeout:** requester 1 granted, sends 1 word, then drops valid; IDLE_TO=8.
  - grant clears 8 cycles after valid drops.
  - to_err pulses exactly one cycle.
  - The next grant goes to requester 2 if it is valid.
- **Reset mid-burst:** reset asserted on the 2nd beat.
  - fifo_wr_en=0 immediately, grant=0.
  - After release, requester 0 wins first even if requester 3 was mid-burst.
